// File: rtl/epmp_alu_sequencer.sv
// Micro-sequencer that fetches a byte-coded program from external memory and
// steers an external accumulator ALU over a shared tri-state operand bus.
//
// Ports:
//   clk, Reset     - system clock; synchronous active-high reset
//   Start          - begin execution at PC=0 (sampled in IDLE only)
//   Mem_Addr/Rd    - program memory address and read strobe
//   Mem_Data       - program memory data, valid the cycle after Mem_Rd
//   ALU_En/Cmd     - one-cycle ALU execute strobe and command
//   ACC_Out_En     - asks the ALU to drive its accumulator onto ACC_bus
//   C              - ALU carry flag, used by JC/JNC
//   ACC_bus        - shared operand/accumulator bus (inout)
//   Out_Data/Valid - stored accumulator value, held until Out_Ready
//   Halted         - HALT reached; terminal until Reset
//   Debug_PC       - current program counter
module epmp_alu_sequencer #(
  parameter int unsigned PC_WIDTH = 8  // legal range 4..8
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Start,
  output logic [PC_WIDTH-1:0] Mem_Addr,
  output logic                Mem_Rd,
  input  logic [7:0]          Mem_Data,
  output logic                ALU_En,
  output logic [3:0]          ALU_Cmd,
  output logic                ACC_Out_En,
  input  logic                C,
  inout  wire  [7:0]          ACC_bus,
  output logic [7:0]          Out_Data,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic                Halted,
  output logic [PC_WIDTH-1:0] Debug_PC
);

  if (PC_WIDTH < 4 || PC_WIDTH > 8) begin : g_bad_width
    $error("epmp_alu_sequencer: PC_WIDTH must be in 4..8");
  end

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StDecode  = 3'd2;
  localparam logic [2:0] StOpFetch = 3'd3;
  localparam logic [2:0] StExec    = 3'd4;
  localparam logic [2:0] StOut     = 3'd5;
  localparam logic [2:0] StHalt    = 3'd6;

  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpJmp   = 4'hA;
  localparam logic [3:0] OpJc    = 4'hB;
  localparam logic [3:0] OpJnc   = 4'hC;
  localparam logic [3:0] OpHalt  = 4'hF;

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  // Only the opcode nibble of the instruction byte is ever used.
  logic [3:0]          ir_q, ir_d;
  logic [7:0]          out_data_q, out_data_d;

  logic                exec;
  logic                alu_op;
  logic                acc_drive;

  function automatic logic has_operand(input logic [3:0] op);
    unique case (op)
      4'h0, 4'h1, 4'h6, 4'h7, 4'h8, OpJmp, OpJc, OpJnc: has_operand = 1'b1;
      default:                                          has_operand = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    out_data_d = out_data_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = StDecode;
      end
      StDecode: begin
        ir_d    = Mem_Data[7:4];
        state_d = has_operand(Mem_Data[7:4]) ? StOpFetch : StExec;
      end
      StOpFetch: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (ir_q)
          OpStore: begin
            out_data_d = ACC_bus;
            state_d    = StOut;
          end
          OpJmp:   pc_d = Mem_Data[PC_WIDTH-1:0];
          OpJc:    if (C)  pc_d = Mem_Data[PC_WIDTH-1:0];
          OpJnc:   if (!C) pc_d = Mem_Data[PC_WIDTH-1:0];
          OpHalt:  state_d = StHalt;
          default: ;  // ALU ops and NOPs simply return to FETCH
        endcase
      end
      StOut: begin
        if (Out_Ready) state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      out_data_q <= out_data_d;
    end
  end

  // All strobes are pure functions of the registered state so they drop on
  // the same edge that Reset lands.
  assign exec       = (state_q == StExec);
  assign alu_op     = (ir_q <= 4'h8);
  assign ALU_En     = exec && alu_op;
  assign ALU_Cmd    = ALU_En ? ir_q : 4'h0;
  assign ACC_Out_En = exec && (ir_q == OpStore);
  assign Mem_Rd     = (state_q == StFetch) || (state_q == StOpFetch);
  assign Mem_Addr   = pc_q;
  assign Debug_PC   = pc_q;
  assign Out_Valid  = (state_q == StOut);
  assign Out_Data   = out_data_q;
  assign Halted     = (state_q == StHalt);

  // Operand is on Mem_Data during EXEC (read in OPFETCH). STORE is never an
  // ALU op, so this can never overlap ACC_Out_En.
  assign acc_drive = ALU_En && has_operand(ir_q);
  assign ACC_bus   = acc_drive ? Mem_Data : 8'hzz;

endmodule

// File: tb/tb_epmp_alu_sequencer.sv
module tb_epmp_alu_sequencer;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Mem_Addr;
  logic       Mem_Rd;
  logic [7:0] Mem_Data;
  logic       ALU_En;
  logic [3:0] ALU_Cmd;
  logic       ACC_Out_En;
  logic       C;
  wire  [7:0] ACC_bus;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Ready = 1'b1;
  logic       Halted;
  logic [7:0] Debug_PC;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  epmp_alu_sequencer #(.PC_WIDTH(8)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Start     (Start),
    .Mem_Addr  (Mem_Addr),
    .Mem_Rd    (Mem_Rd),
    .Mem_Data  (Mem_Data),
    .ALU_En    (ALU_En),
    .ALU_Cmd   (ALU_Cmd),
    .ACC_Out_En(ACC_Out_En),
    .C         (C),
    .ACC_bus   (ACC_bus),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Halted    (Halted),
    .Debug_PC  (Debug_PC)
  );

  // Program memory: registered read, data one cycle after Mem_Rd.
  logic [7:0] mem [256];
  logic [7:0] mem_q = 8'h00;
  always @(posedge clk) if (Mem_Rd) mem_q <= mem[Mem_Addr];
  assign Mem_Data = mem_q;

  // Accumulator ALU model.
  logic [7:0] acc = 8'h00;
  logic       c_q = 1'b0;
  assign C       = c_q;
  assign ACC_bus = ACC_Out_En ? acc : 8'hzz;
  always @(posedge clk) begin
    if (Reset) begin
      acc <= 8'h00;
      c_q <= 1'b0;
    end else if (ALU_En) begin
      case (ALU_Cmd)
        4'h0: {c_q, acc} <= {1'b0, acc} + {1'b0, ACC_bus};
        4'h1: {c_q, acc} <= {1'b0, acc} - {1'b0, ACC_bus};
        4'h2: begin acc <= 8'h00; c_q <= 1'b0; end
        4'h3: acc <= 8'h00 - acc;
        4'h4: {c_q, acc} <= {1'b0, acc} + 9'd1;
        4'h5: {c_q, acc} <= {1'b0, acc} - 9'd1;
        4'h6: acc <= acc & ACC_bus;
        4'h7: acc <= acc | ACC_bus;
        4'h8: begin acc <= ACC_bus; c_q <= 1'b0; end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus-protocol monitor, runs for the whole simulation.
  always @(negedge clk) begin
    if (!Reset) begin
      check("alu_en_vs_acc_out_en", {31'd0, ALU_En && ACC_Out_En}, 32'd0);
      check("bus_drive_vs_acc_out_en", {31'd0, dut.acc_drive && (ACC_Out_En || !ALU_En)}, 32'd0);
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
  endtask

  task automatic load_prog(input logic [63:0] prog);
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    for (int i = 0; i < 8; i++) mem[i] = prog[63-8*i -: 8];
  endtask

  // Pulse Start; returns #1 after the edge that enters FETCH.
  task automatic kick();
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  logic [7:0] fa [8];
  int         fn;
  task automatic collect(input int want);
    fn = 0;
    for (int cyc = 0; cyc < 60 && fn < want; cyc++) begin
      if (Mem_Rd) begin
        fa[fn] = Mem_Addr;
        fn++;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] prog;
    logic [7:0]  exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];
  int   lat;

  initial begin
    vecs[0] = '{"add",  64'h80_05_00_03_90_F0_F0_F0, 8'h08, 11};
    vecs[1] = '{"sub",  64'h80_0A_10_03_90_F0_F0_F0, 8'h07, 11};
    vecs[2] = '{"and",  64'h80_5A_60_0F_90_F0_F0_F0, 8'h0A, 11};
    vecs[3] = '{"or",   64'h80_50_7F_0A_90_F0_F0_F0, 8'h5A, 11};
    vecs[4] = '{"clr",  64'h80_12_20_90_F0_F0_F0_F0, 8'h00, 10};
    vecs[5] = '{"neg",  64'h80_01_30_90_F0_F0_F0_F0, 8'hFF, 10};
    vecs[6] = '{"inr",  64'h80_FF_40_90_F0_F0_F0_F0, 8'h00, 10};
    vecs[7] = '{"dcr",  64'h80_00_50_90_F0_F0_F0_F0, 8'hFF, 10};
    vecs[8] = '{"nop",  64'h80_03_D0_E0_90_F0_F0_F0, 8'h03, 13};
    vecs[9] = '{"jmp",  64'h80_07_A0_05_F0_90_F0_F0, 8'h07, 11};

    // Reset state.
    load_prog(vecs[0].prog);
    do_reset();
    check("rst_mem_rd", {31'd0, Mem_Rd}, 32'd0);
    check("rst_alu_en", {31'd0, ALU_En}, 32'd0);
    check("rst_acc_out_en", {31'd0, ACC_Out_En}, 32'd0);
    check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    check("rst_halted", {31'd0, Halted}, 32'd0);
    check("rst_pc", {24'd0, Debug_PC}, 32'd0);
    check("rst_bus_drive", {31'd0, dut.acc_drive}, 32'd0);

    // Table-driven programs: result, Start-to-Out_Valid latency, then HALT.
    Out_Ready = 1'b1;
    foreach (vecs[v]) begin
      load_prog(vecs[v].prog);
      do_reset();
      kick();
      lat = 0;
      while (!Out_Valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      check({vecs[v].name, "_out_valid"}, {31'd0, Out_Valid}, 32'd1);
      check({vecs[v].name, "_out_data"}, {24'd0, Out_Data}, {24'd0, vecs[v].exp_out});
      check({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
      for (int i = 0; i < 20 && !Halted; i++) begin
        @(posedge clk); #1;
      end
      check({vecs[v].name, "_halted"}, {31'd0, Halted}, 32'd1);
    end

    // HALT ignores Start.
    kick();
    @(posedge clk); #1;
    check("halt_ignores_start", {31'd0, Halted}, 32'd1);
    check("halt_no_fetch", {31'd0, Mem_Rd}, 32'd0);

    // Reset clears a stored Out_Data.
    do_reset();
    check("rst_out_data", {24'd0, Out_Data}, 32'd0);
    check("rst_clears_halt", {31'd0, Halted}, 32'd0);

    // LOAD 05: ALU strobe exactly in the 4th cycle after Start.
    load_prog(vecs[0].prog);
    do_reset();
    kick();
    for (int n = 0; n < 5; n++) begin
      if (n == 0) check("first_fetch_addr", {23'd0, Mem_Rd, Mem_Addr}, 32'h100);
      if (n == 2) check("no_alu_in_opfetch", {31'd0, ALU_En}, 32'd0);
      if (n == 3) begin
        check("load_alu_en", {31'd0, ALU_En}, 32'd1);
        check("load_alu_cmd", {28'd0, ALU_Cmd}, 32'd8);
        check("load_bus", {24'd0, ACC_bus}, 32'h05);
        check("load_pc", {24'd0, Debug_PC}, 32'd2);
      end
      if (n == 4) check("alu_en_one_cycle", {31'd0, ALU_En}, 32'd0);
      @(posedge clk); #1;
    end

    // Back-pressure in OUT.
    Out_Ready = 1'b0;
    load_prog(vecs[0].prog);
    do_reset();
    kick();
    for (int i = 0; i < 40 && !Out_Valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, Out_Valid}, 32'd1);
      check("bp_out_data", {24'd0, Out_Data}, 32'h08);
      check("bp_mem_rd", {31'd0, Mem_Rd}, 32'd0);
      check("bp_pc", {24'd0, Debug_PC}, 32'd5);
      @(posedge clk); #1;
    end
    check("bp_still_valid", {31'd0, Out_Valid}, 32'd1);
    Out_Ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accepted", {31'd0, Out_Valid}, 32'd0);
    check("bp_next_fetch", {23'd0, Mem_Rd, Mem_Addr}, 32'h105);

    // JC taken after INR carry, then JNC not taken.
    load_prog(64'h80_FF_40_B0_20_F0_F0_F0);
    do_reset();
    kick();
    collect(6);
    check("jc_fetch_count", fn, 6);
    check("jc_target", {24'd0, fa[5]}, 32'h20);
    load_prog(64'h80_FF_40_C0_20_F0_F0_F0);
    do_reset();
    kick();
    collect(6);
    check("jnc_fetch_count", fn, 6);
    check("jnc_fallthrough", {24'd0, fa[5]}, 32'h05);

    // PC wrap: JMP FF, NOP at FF, next fetch at 00.
    load_prog(64'hA0_FF_F0_F0_F0_F0_F0_F0);
    mem[255] = 8'hD0;
    do_reset();
    kick();
    collect(4);
    check("wrap_count", fn, 4);
    check("wrap_a0", {24'd0, fa[0]}, 32'h00);
    check("wrap_a1", {24'd0, fa[1]}, 32'h01);
    check("wrap_a2", {24'd0, fa[2]}, 32'hFF);
    check("wrap_a3", {24'd0, fa[3]}, 32'h00);

    // Reset during EXEC of an ALU op, with Start held high.
    load_prog(vecs[0].prog);
    do_reset();
    kick();
    for (int i = 0; i < 10 && !ALU_En; i++) begin
      @(posedge clk); #1;
    end
    check("exec_reached", {31'd0, ALU_En}, 32'd1);
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge clk); #1;
    check("xrst_alu_en", {31'd0, ALU_En}, 32'd0);
    check("xrst_bus_drive", {31'd0, dut.acc_drive}, 32'd0);
    check("xrst_pc", {24'd0, Debug_PC}, 32'd0);
    check("xrst_mem_rd", {31'd0, Mem_Rd}, 32'd0);
    Reset = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0;
    check("restart_fetch", {23'd0, Mem_Rd, Mem_Addr}, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
